handshake_fifo: RTL
===================

Name: handshake_fifo

Overview:
- Elastic buffer on the handshake data path, between the `source` stage and the `drain` stage in `test`.
- Decouples producer and consumer timing with a valid/ready FIFO carrying the WIDTH-bit `port1` payload.
- Upstream face is the producer (dir1-style output data); downstream face is the consumer.
- Absorbs back-pressure so the source never stalls on a single-cycle drain hiccup.

Parameters:
- WIDTH, 32, payload width in bits; matches the handshake interface WIDTH.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO accepts in_data this cycle.
- in_data  input  WIDTH  payload from the source stage (port1).
- out_valid  output  1  out_data holds the head entry.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  WIDTH  head payload toward the drain stage.
- count  output  AW+1  occupancy; present only with HANDSHAKE_FIFO_COUNT_EN.

Behaviour:
- Reset (clk edge with rst=1):
  - wr_ptr=0, rd_ptr=0, occupancy=0, all storage entries=0.
  - Outputs: in_ready=0 while rst=1, then 1 on the first cycle after release; out_valid=0; out_data=0.
- Transfer rules:
  - Push occurs when in_valid & in_ready at a clk edge.
  - Pop occurs when out_valid & out_ready at a clk edge.
  - Producer holds in_data stable while in_valid=1 and in_ready=0.
  - The block never drops out_valid or changes out_data until a pop.
- Flags:
  - in_ready = !rst & (occupancy != DEPTH). It is derived from registered state only, so there is no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_data = storage[rd_ptr] (first-word fall-through).
- Latency: a push into an empty FIFO gives out_valid=1 and out_data=pushed value in the next cycle. No same-cycle bypass.
- Pointers:
  - AW bits wide; increment modulo DEPTH on push/pop; wrap from DEPTH-1 to 0.
  - Occupancy register is AW+1 bits, range 0..DEPTH.
- Simultaneous push and pop (occupancy in 1..DEPTH-1): both pointers advance and occupancy is unchanged.
- Full (occupancy=DEPTH): in_ready=0. A pop in this cycle frees a slot, but in_ready only rises on the next cycle.
- Empty: out_valid=0, and out_data shows storage[rd_ptr], the last popped value or 0 after reset.
- Reset mid-operation: all contents are discarded; the state equals the post-reset state in the next cycle, regardless of in_valid/out_ready.
- Ordering: strict FIFO; no reordering, duplication or loss.

Optional Feature:
- Macro: HANDSHAKE_FIFO_COUNT_EN.
- Defined:
  - `count` port exists and is driven from the occupancy register (registered, reset 0).
  - Reading it adds no logic to the in_ready or out_valid paths.
- Undefined: the `count` port is absent. Occupancy stays internal and is used only for the full/empty flags.

Decomposition:
- Shared package handshake_pkg:
  - HS_WIDTH_DEFAULT=32 and HS_DEPTH_DEFAULT=4.
  - Typedef hs_data_t = logic [HS_WIDTH_DEFAULT-1:0].
  - Function hs_ptr_inc(ptr, depth) for modulo increment.
- One sub-module, handshake_fifo_mem:
  - DEPTH x WIDTH register array with synchronous reset to 0.
  - Single write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
  - All pointer/flag control stays in handshake_fifo.

Test Plan:
- Reset: rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, count=0 throughout. In the first cycle after release, in_ready=1.
- Fill/drain: out_ready=0, push 0x11,0x22,0x33,0x44 -> in_ready=0 after the 4th push, count=4. Then out_ready=1 -> outputs 0x11..0x44 in order, out_valid=0 after the 4th pop.
- Latency: empty FIFO, push 0xDEADBEEF at edge N -> out_valid=1 and out_data=0xDEADBEEF in cycle N+1, not N.
- Streaming: in_valid=out_ready=1 continuously with values 1..100 -> after the first cycle one pop per cycle, count constant at 1, outputs 1..100. Pointers wrap 25 times with no loss.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop accepted, push refused that cycle. Next cycle in_ready=1, push accepted, count=4 again.
- Mid-stream reset: count=3, rst pulse of 1 cycle -> next cycle count=0, out_valid=0, out_data=0. A later push 0x5 appears as the first output.

Source files
------------

// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the handshake data path (source -> fifo -> drain).
//   HS_WIDTH_DEFAULT : default payload width in bits
//   HS_DEPTH_DEFAULT : default elastic buffer depth (entries)
//   hs_data_t        : payload type at the default width
//   hs_ptr_inc       : modulo-depth pointer increment helper
// -----------------------------------------------------------------------------
package handshake_pkg;

    localparam int HS_WIDTH_DEFAULT = 32;
    localparam int HS_DEPTH_DEFAULT = 4;

    typedef logic [HS_WIDTH_DEFAULT-1:0] hs_data_t;

    // Advance a ring pointer by one, wrapping from depth-1 back to 0.
    function automatic logic [31:0] hs_ptr_inc(input logic [31:0] ptr,
                                               input logic [31:0] depth);
        logic [31:0] nxt_s;
        if (ptr == (depth - 32'd1)) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = ptr + 32'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// -----------------------------------------------------------------------------
// handshake_fifo_mem
// DEPTH x WIDTH register array backing the handshake FIFO.
// Ports:
//   clk   : clock, all writes on rising edge
//   rst   : synchronous active-high reset, clears every entry to 0
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data, storage[raddr]
// -----------------------------------------------------------------------------
module handshake_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage update: clear on reset, otherwise single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// -----------------------------------------------------------------------------
// handshake_fifo
// Valid/ready elastic buffer between the source and drain stages. First-word
// fall-through: the head entry is visible on out_data whenever out_valid is 1.
// in_ready depends only on registered occupancy (and rst), so there is no
// combinational path from out_ready to in_ready.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : producer handshake, in_data is the payload
//   out_valid/out_ready : consumer handshake, out_data is the head payload
//   count               : occupancy (0..DEPTH), only when
//                         HANDSHAKE_FIFO_COUNT_EN is defined
// Optional feature macro: HANDSHAKE_FIFO_COUNT_EN
// -----------------------------------------------------------------------------
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH_DEFAULT,
    parameter int DEPTH = HS_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef HANDSHAKE_FIFO_COUNT_EN
    ,
    output logic [AW:0]      count
`endif
);

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_ZERO = (AW+1)'(0);
    localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   occ_r;
    logic          push_s;
    logic          pop_s;

    assign in_ready  = !rst && (occ_r != OCC_FULL);
    assign out_valid = (occ_r != OCC_ZERO);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Pointer and occupancy bookkeeping; push and pop together keep occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= AW'(hs_ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
            end
            if (pop_s) begin
                rd_ptr_r <= AW'(hs_ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    handshake_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_data),
        .raddr (rd_ptr_r),
        .rdata (out_data)
    );

`ifdef HANDSHAKE_FIFO_COUNT_EN
    // Occupancy register exported as-is; it feeds no flag logic.
    assign count = occ_r;
`endif

endmodule
